// File: rtl/sprite_palette_pkg.sv
// Shared types, reset palette contents and colour arithmetic for the sprite palette engine.
// Contents: rgb12_t, flash_state_t, DEFAULT_PAL, sat_add4, default_entry.
// No ports (package).
package sprite_palette_pkg;

  typedef logic [11:0] rgb12_t;

  typedef enum logic [1:0] {
    FL_IDLE   = 2'd0,
    FL_BRIGHT = 2'd1,
    FL_NORMAL = 2'd2
  } flash_state_t;

  localparam int DEF_PAL_N = 8;

  // Palette 0 contents after reset, entries 0..7.
  localparam rgb12_t DEFAULT_PAL [DEF_PAL_N] = '{
    12'h000, 12'h0E1, 12'hC20, 12'hB76,
    12'h070, 12'h610, 12'h644, 12'hEA9
  };

  // 4-bit add that clips at 4'hF instead of wrapping.
  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction

  // Reset value of one palette entry: palette 0 gets the defaults, everything else black.
  function automatic rgb12_t default_entry(input int pal, input int idx);
    if (pal == 0 && idx < DEF_PAL_N) return DEFAULT_PAL[idx];
    return '0;
  endfunction

endpackage

// File: rtl/palette_flash_fsm.sv
// Hit-flash sequencer: alternates BRIGHT/NORMAL every FLASH_PERIOD frame ticks for FLASH_LEN ticks.
// Ports: clk_i, rst_ni, frame_tick_i, flash_trig_i in; flash_busy_o, bright_o out.
// A trigger always (re)starts the flash in BRIGHT and swallows a coincident frame tick.
module palette_flash_fsm
  import sprite_palette_pkg::*;
#(
  parameter int FLASH_LEN    = 16,
  parameter int FLASH_PERIOD = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic frame_tick_i,
  input  logic flash_trig_i,
  output logic flash_busy_o,
  output logic bright_o
);

  localparam int REM_W = $clog2(FLASH_LEN + 1);
  localparam int PH_W  = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam logic [REM_W-1:0] LEN_C   = REM_W'(FLASH_LEN);
  localparam logic [REM_W-1:0] ONE_C   = REM_W'(1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(FLASH_PERIOD - 1);
  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);

  flash_state_t     state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [PH_W-1:0]  phase_q, phase_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FL_IDLE;
      rem_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    phase_d = phase_q;
    if (flash_trig_i) begin
      state_d = FL_BRIGHT;
      rem_d   = LEN_C;
      phase_d = '0;
    end else if (frame_tick_i && state_q != FL_IDLE) begin
      rem_d = rem_q - ONE_C;
      if (rem_q == ONE_C) begin
        // Running out of ticks ends the flash even on a phase boundary.
        state_d = FL_IDLE;
        phase_d = '0;
      end else if (phase_q == PH_LAST) begin
        phase_d = '0;
        state_d = (state_q == FL_BRIGHT) ? FL_NORMAL : FL_BRIGHT;
      end else begin
        phase_d = phase_q + PH_ONE;
      end
    end
  end

  assign flash_busy_o = (state_q != FL_IDLE);
  assign bright_o     = (state_q == FL_BRIGHT);

endmodule

// File: rtl/sprite_palette_engine.sv
// Writable multi-palette colour lookup for sprite pixels with hit-flash brightening.
// Ports: Clk, Reset_n; palette write (wr_*); lookup (rd_*); frame_tick, flash_trig; RGB/valid/transparent/flash_busy out.
// Fixed 2-cycle lookup latency, one request per cycle, never stalls; writes are read-before-write.
module sprite_palette_engine
  import sprite_palette_pkg::*;
#(
  parameter int         IDX_W        = 3,
  parameter int         NUM_PAL      = 4,
  parameter int         FLASH_LEN    = 16,
  parameter int         FLASH_PERIOD = 2,
  parameter logic [3:0] BRIGHT       = 4'h6
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [11:0]                wr_rgb,
  input  logic                       rd_valid,
  input  logic [$clog2(NUM_PAL)-1:0] rd_pal,
  input  logic [IDX_W-1:0]           rd_idx,
  input  logic                       frame_tick,
  input  logic                       flash_trig,
  output logic                       flash_busy,
  output logic                       out_valid,
  output logic [3:0]                 red,
  output logic [3:0]                 green,
  output logic [3:0]                 blue,
  output logic                       out_transparent
);

  localparam int NENT = 2 ** IDX_W;

  rgb12_t pal_q [NUM_PAL][NENT];

  logic   s1_vld_q;
  rgb12_t s1_rgb_q;
  logic   s1_transp_q;

  logic   out_vld_q;
  rgb12_t out_rgb_q;
  logic   out_transp_q;

  logic   bright;
  rgb12_t bright_rgb;

  // Palette storage; S1 samples the pre-write contents on the same edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PAL; p++) begin
        for (int e = 0; e < NENT; e++) begin
          pal_q[p][e] <= default_entry(p, e);
        end
      end
    end else if (wr_en) begin
      pal_q[wr_pal][wr_idx] <= wr_rgb;
    end
  end

  // S1: entry fetch.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_vld_q    <= 1'b0;
      s1_rgb_q    <= '0;
      s1_transp_q <= 1'b0;
    end else begin
      s1_vld_q <= rd_valid;
      if (rd_valid) begin
        s1_rgb_q    <= pal_q[rd_pal][rd_idx];
        s1_transp_q <= (rd_idx == '0);
      end
    end
  end

  palette_flash_fsm #(
    .FLASH_LEN    (FLASH_LEN),
    .FLASH_PERIOD (FLASH_PERIOD)
  ) u_flash (
    .clk_i        (Clk),
    .rst_ni       (Reset_n),
    .frame_tick_i (frame_tick),
    .flash_trig_i (flash_trig),
    .flash_busy_o (flash_busy),
    .bright_o     (bright)
  );

  always_comb begin
    bright_rgb = {sat_add4(s1_rgb_q[11:8], BRIGHT),
                  sat_add4(s1_rgb_q[7:4],  BRIGHT),
                  sat_add4(s1_rgb_q[3:0],  BRIGHT)};
  end

  // S2: flash effect using the phase current at this stage; outputs hold when idle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_vld_q    <= 1'b0;
      out_rgb_q    <= '0;
      out_transp_q <= 1'b0;
    end else begin
      out_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        out_rgb_q    <= (bright && !s1_transp_q) ? bright_rgb : s1_rgb_q;
        out_transp_q <= s1_transp_q;
      end
    end
  end

  assign out_valid       = out_vld_q;
  assign {red, green, blue} = out_rgb_q;
  assign out_transparent = out_transp_q;

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Self-checking bench for sprite_palette_engine against a behavioural palette/flash model.
// Inputs change on the falling edge; outputs are compared on the next falling edge.
// Directed scenarios first, then a randomized run.
module tb_sprite_palette_engine;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        wr_en;
  logic [1:0]  wr_pal;
  logic [2:0]  wr_idx;
  logic [11:0] wr_rgb;
  logic        rd_valid;
  logic [1:0]  rd_pal;
  logic [2:0]  rd_idx;
  logic        frame_tick;
  logic        flash_trig;
  logic        flash_busy;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        out_transparent;

  always #5 Clk = ~Clk;

  sprite_palette_engine dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .wr_en           (wr_en),
    .wr_pal          (wr_pal),
    .wr_idx          (wr_idx),
    .wr_rgb          (wr_rgb),
    .rd_valid        (rd_valid),
    .rd_pal          (rd_pal),
    .rd_idx          (rd_idx),
    .frame_tick      (frame_tick),
    .flash_trig      (flash_trig),
    .flash_busy      (flash_busy),
    .out_valid       (out_valid),
    .red             (red),
    .green           (green),
    .blue            (blue),
    .out_transparent (out_transparent)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int FLASH_LEN    = 16;
  localparam int FLASH_PERIOD = 2;
  localparam int BRIGHT_ADD   = 6;

  logic [11:0] def_pal [8] = '{12'h000, 12'h0E1, 12'hC20, 12'hB76,
                               12'h070, 12'h610, 12'h644, 12'hEA9};
  logic [11:0] m_pal [4][8];
  logic        m_s1_vld, m_s1_tr, m_out_vld, m_out_tr;
  logic [11:0] m_s1_rgb, m_out_rgb;
  int          m_rem;      // frame ticks left in the flash (0 = no flash)
  int          m_elapsed;  // frame ticks since the flash started

  function automatic logic m_bright();
    return (m_rem > 0) && (((m_elapsed / FLASH_PERIOD) % 2) == 0);
  endfunction

  function automatic logic [3:0] ch_up(input logic [3:0] c);
    int v;
    v = int'(c) + BRIGHT_ADD;
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  function automatic logic [11:0] brighten(input logic [11:0] c);
    return {ch_up(c[11:8]), ch_up(c[7:4]), ch_up(c[3:0])};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 4; p++)
      for (int e = 0; e < 8; e++)
        m_pal[p][e] = (p == 0) ? def_pal[e] : 12'h000;
    m_s1_vld = 0; m_s1_tr = 0; m_s1_rgb = '0;
    m_out_vld = 0; m_out_tr = 0; m_out_rgb = '0;
    m_rem = 0; m_elapsed = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"},   {31'd0, out_valid},       {31'd0, m_out_vld});
    chk({tag, ".rgb"},         {20'd0, red, green, blue}, {20'd0, m_out_rgb});
    chk({tag, ".transparent"}, {31'd0, out_transparent}, {31'd0, m_out_tr});
    chk({tag, ".flash_busy"},  {31'd0, flash_busy},      {31'd0, m_rem > 0});
  endtask

  // One clock: drive inputs, advance the model over the edge, compare afterwards.
  task automatic step(input logic we, input logic [1:0] wp, input logic [2:0] wi,
                      input logic [11:0] wd, input logic rv, input logic [1:0] rp,
                      input logic [2:0] ri, input logic tk, input logic tg);
    logic br;
    wr_en = we; wr_pal = wp; wr_idx = wi; wr_rgb = wd;
    rd_valid = rv; rd_pal = rp; rd_idx = ri;
    frame_tick = tk; flash_trig = tg;
    br = m_bright();
    m_out_vld = m_s1_vld;
    if (m_s1_vld) begin
      m_out_rgb = (br && !m_s1_tr) ? brighten(m_s1_rgb) : m_s1_rgb;
      m_out_tr  = m_s1_tr;
    end
    m_s1_vld = rv;
    if (rv) begin
      m_s1_rgb = m_pal[rp][ri];
      m_s1_tr  = (ri == 0);
    end
    if (we) m_pal[wp][wi] = wd;
    if (tg) begin
      m_rem = FLASH_LEN; m_elapsed = 0;
    end else if (tk && m_rem > 0) begin
      m_rem--; m_elapsed++;
    end
    @(posedge Clk);
    @(negedge Clk);
    check_all("cyc");
  endtask

  task automatic lookup(input logic [1:0] p, input logic [2:0] i);
    step(0, 2'd0, 3'd0, 12'h0, 1, p, i, 0, 0);
  endtask

  task automatic idle();
    step(0, 2'd0, 3'd0, 12'h0, 0, 2'd0, 3'd0, 0, 0);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0;
    wr_en = 0; wr_pal = 0; wr_idx = 0; wr_rgb = 0;
    rd_valid = 0; rd_pal = 0; rd_idx = 0;
    frame_tick = 0; flash_trig = 0;
    model_reset();
    #3;
    check_all("por");
    @(negedge Clk);
    Reset_n = 1'b1;

    // 1: basic lookup and transparency
    lookup(2'd0, 3'd2);
    idle();
    chk("t1.rgb_c20", {20'd0, red, green, blue}, 32'hC20);
    lookup(2'd0, 3'd0);
    idle();
    chk("t1.transp", {31'd0, out_transparent}, 32'd1);

    // 2: read-before-write, then new value
    step(1, 2'd2, 3'd5, 12'h3A7, 1, 2'd2, 3'd5, 0, 0);
    lookup(2'd2, 3'd5);
    chk("t2.old", {20'd0, red, green, blue}, 32'h000);
    lookup(2'd0, 3'd5);
    chk("t2.new", {20'd0, red, green, blue}, 32'h3A7);
    idle();
    chk("t2.pal0", {20'd0, red, green, blue}, 32'h610);

    // 3: back-to-back
    lookup(2'd0, 3'd1);
    lookup(2'd0, 3'd3);
    lookup(2'd0, 3'd7);
    idle();
    idle();

    // 4: brightening under flash
    step(0, 2'd0, 3'd0, 12'h0, 0, 2'd0, 3'd0, 0, 1);
    lookup(2'd0, 3'd7);
    lookup(2'd0, 3'd4);
    chk("t4.sat", {20'd0, red, green, blue}, 32'hFFF);
    lookup(2'd0, 3'd0);
    chk("t4.bright", {20'd0, red, green, blue}, 32'h6D6);
    idle();
    idle();

    // 5: full flash sequence, then restart on tick 9 (trigger beats tick)
    step(0, 2'd0, 3'd0, 12'h0, 0, 2'd0, 3'd0, 0, 1);
    for (int k = 1; k <= 16; k++) step(0, 2'd0, 3'd0, 12'h0, 1, 2'd0, 3'd3, 1, 0);
    chk("t5.done", {31'd0, flash_busy}, 32'd0);
    step(0, 2'd0, 3'd0, 12'h0, 0, 2'd0, 3'd0, 0, 1);
    for (int k = 1; k <= 8; k++) step(0, 2'd0, 3'd0, 12'h0, 1, 2'd0, 3'd3, 1, 0);
    step(0, 2'd0, 3'd0, 12'h0, 1, 2'd0, 3'd3, 1, 1);
    for (int k = 1; k <= 15; k++) step(0, 2'd0, 3'd0, 12'h0, 1, 2'd0, 3'd6, 1, 0);
    chk("t5.still_busy", {31'd0, flash_busy}, 32'd1);
    step(0, 2'd0, 3'd0, 12'h0, 1, 2'd0, 3'd6, 1, 0);
    chk("t5.restart_done", {31'd0, flash_busy}, 32'd0);

    // 6: reset mid-flash with lookups in flight
    step(1, 2'd2, 3'd5, 12'h3A7, 0, 2'd0, 3'd0, 0, 1);
    step(0, 2'd0, 3'd0, 12'h0, 1, 2'd2, 3'd5, 1, 0);
    step(0, 2'd0, 3'd0, 12'h0, 1, 2'd0, 3'd7, 0, 0);
    #1;
    do_reset();
    lookup(2'd2, 3'd5);
    idle();
    chk("t6.cleared", {20'd0, red, green, blue}, 32'h000);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      step($urandom_range(3, 0) == 0, 2'($urandom), 3'($urandom), 12'($urandom),
           $urandom_range(9, 0) < 7, 2'($urandom), 3'($urandom),
           $urandom_range(3, 0) == 0, $urandom_range(39, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
